// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS controller: opcode and
// memory handshake in, datapath enables and selects out.
interface multicycle_control_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           opcode;
  logic                 mem_ready;
  logic                 mem_read;
  logic                 mem_write;
  logic                 iord;
  logic                 ir_write;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 reg_write;
  logic [1:0]           reg_dst;
  logic [1:0]           mem_to_reg;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic                 immediate_or;
  logic                 immediate_load_upper;
  logic [1:0]           pc_source;
  logic                 exception;
  logic [1:0]           cause;
  logic [CNT_WIDTH-1:0] retired_count;
  logic [3:0]           state;

  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           immediate_or, immediate_load_upper, pc_source, exception,
           cause, retired_count, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           immediate_or, immediate_load_upper, pc_source, exception,
           cause, retired_count, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory-ready timeout, exception redirect
// and retired-instruction counter.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_IMM_EXE   = 4'd10,
    S_IMM_WB    = 4'd11,
    S_JUMP      = 4'd12,
    S_EXCEPT    = 4'd13
  } state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       imm_or;
    logic       imm_lui;
    logic [1:0] pc_source;
    logic       exception;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam int              TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic            TMO_EN   = (MEM_TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic [TMO_W-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? TMO_W'(MEM_TIMEOUT - 1) : '0;

  // Opcode is stable from DECODE onward, so decoding outputs for the state
  // being entered gives the same result as decoding the current state.
  function automatic ctl_t decode_ctl(input state_e s, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXECUTE:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_ALU_WB:    begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_IMM_EXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b11;
        c.imm_or    = (op == OP_ORI);
        c.imm_lui   = (op == OP_LUI);
      end
      S_IMM_WB:    c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.reg_write  = (op == OP_JAL);
        c.reg_dst    = (op == OP_JAL) ? 2'b10 : 2'b00;
        c.mem_to_reg = (op == OP_JAL) ? 2'b10 : 2'b00;
      end
      S_EXCEPT: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b11;
        c.exception = 1'b1;
      end
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_e               state_q, state_d;
  ctl_t                 ctl_q;
  logic [1:0]           cause_q, cause_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 retire_s;
  logic                 timeout_s;
  logic                 mem_state_s;

  assign mem_state_s = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timeout_s   = TMO_EN && (tmo_q == TMO_LAST) && !bus.mem_ready;

  // Next-state, exception cause, retire and timeout-counter logic.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    retire_s = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_EXCEPT;
          cause_d = 2'b10;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_LW, OP_SW:   state_d = S_MEM_ADR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_ORI, OP_LUI: state_d = S_IMM_EXE;
          OP_J, OP_JAL:   state_d = S_JUMP;
          default: begin
            state_d = S_EXCEPT;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEM_ADR: state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_s) begin
          state_d = S_EXCEPT;
          cause_d = 2'b10;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else if (timeout_s) begin
          state_d = S_EXCEPT;
          cause_d = 2'b10;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_EXECUTE: state_d = S_ALU_WB;
      S_IMM_EXE: state_d = S_IMM_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_IMM_WB, S_JUMP: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_EXCEPT: state_d = S_FETCH;
      default:  state_d = S_RESET;
    endcase

    if ((state_d != state_q) &&
        ((state_d == S_FETCH) || (state_d == S_MEM_READ) || (state_d == S_MEM_WRITE))) begin
      tmo_d = '0;
    end else if (TMO_EN && mem_state_s && !bus.mem_ready) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // State, registered Moore outputs, cause, timeout and retire counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      ctl_q   <= '0;
      cause_q <= 2'b00;
      tmo_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode_ctl(state_d, bus.opcode);
      cause_q <= cause_d;
      tmo_q   <= tmo_d;
      count_q <= count_q + CNT_WIDTH'(retire_s);
    end
  end

  // IR and PC load in FETCH only on the cycle the read completes.
  logic fetch_done_s;
  assign fetch_done_s = (state_q == S_FETCH) && bus.mem_ready;

  assign bus.mem_read             = ctl_q.mem_read;
  assign bus.mem_write            = ctl_q.mem_write;
  assign bus.iord                 = ctl_q.iord;
  assign bus.ir_write             = fetch_done_s;
  assign bus.pc_write             = ctl_q.pc_write | fetch_done_s;
  assign bus.pc_write_cond        = ctl_q.pc_write_cond;
  assign bus.reg_write            = ctl_q.reg_write;
  assign bus.reg_dst              = ctl_q.reg_dst;
  assign bus.mem_to_reg           = ctl_q.mem_to_reg;
  assign bus.alu_src_a            = ctl_q.alu_src_a;
  assign bus.alu_src_b            = ctl_q.alu_src_b;
  assign bus.alu_op               = ctl_q.alu_op;
  assign bus.immediate_or         = ctl_q.imm_or;
  assign bus.immediate_load_upper = ctl_q.imm_lui;
  assign bus.pc_source            = ctl_q.pc_source;
  assign bus.exception            = ctl_q.exception;
  assign bus.cause                = cause_q;
  assign bus.retired_count        = count_q;
  assign bus.state                = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (MEM_TIMEOUT=4, CNT_WIDTH=4).
module tb_multicycle_control;

  logic clock;
  logic reset_n;
  int   tests;
  int   fails;

  multicycle_control_if #(.CNT_WIDTH(4)) bus ();

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [20:0] ctl;
    logic [1:0] cause;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  logic [20:0] act_ctl;
  assign act_ctl = {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                    bus.pc_write_cond, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.immediate_or,
                    bus.immediate_load_upper, bus.pc_source, bus.exception};

  function automatic logic [20:0] mk(input logic mr, mw, io, irw, pcw, pcc, rw,
                                     input logic [1:0] rd, mtr, input logic asa,
                                     input logic [1:0] asb, aop, input logic ior, lui,
                                     input logic [1:0] pcs, input logic exc);
    return {mr, mw, io, irw, pcw, pcc, rw, rd, mtr, asa, asb, aop, ior, lui, pcs, exc};
  endfunction

  logic [20:0] C_RST, C_FW, C_FR, C_DEC, C_MADR, C_MRD, C_MWB, C_MWR, C_EXE, C_AWB;
  logic [20:0] C_BR, C_ORI, C_LUI, C_IWB, C_J, C_JAL, C_EXC;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, ORI = 6'b001101;
  localparam logic [5:0] LUI = 6'b001111, J = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;
  localparam logic [5:0] RT = 6'b000000;

  function automatic void add(input logic r, input logic [5:0] op, input logic rdy,
                              input logic [3:0] st, input logic [20:0] ctl,
                              input logic [1:0] cause, input logic [3:0] cnt);
    vec_t v;
    v.rst_n = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cause = cause; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [3:0] est, input logic [20:0] ectl,
                      input logic [1:0] ecause, input logic [3:0] ecnt, input string name);
    reset_n    = r;
    bus.opcode = op;
    bus.mem_ready = rdy;
    #1;
    tests++;
    if ({bus.state, act_ctl, bus.cause, bus.retired_count} !== {est, ectl, ecause, ecnt}) begin
      fails++;
      $display("FAIL %s: got state=%0d ctl=%h cause=%0d cnt=%0d, want state=%0d ctl=%h cause=%0d cnt=%0d",
               name, bus.state, act_ctl, bus.cause, bus.retired_count, est, ectl, ecause, ecnt);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //        mr mw io irw pcw pcc rw rd    mtr   asa asb   aop   ior lui pcs   exc
    C_RST  = '0;
    C_FW   = mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd1, 2'd0, 0, 0, 2'd0, 0);
    C_FR   = mk(1, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 2'd1, 2'd0, 0, 0, 2'd0, 0);
    C_DEC  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd3, 2'd0, 0, 0, 2'd0, 0);
    C_MADR = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 0, 0, 2'd0, 0);
    C_MRD  = mk(1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
    C_MWB  = mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
    C_MWR  = mk(0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
    C_EXE  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 2'd2, 0, 0, 2'd0, 0);
    C_AWB  = mk(0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
    C_BR   = mk(0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 1, 2'd0, 2'd1, 0, 0, 2'd1, 0);
    C_ORI  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 2'd3, 1, 0, 2'd0, 0);
    C_LUI  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 2'd3, 0, 1, 2'd0, 0);
    C_IWB  = mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
    C_J    = mk(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 2'd2, 0);
    C_JAL  = mk(0, 0, 0, 0, 1, 0, 1, 2'd2, 2'd2, 0, 2'd0, 2'd0, 0, 0, 2'd2, 0);
    C_EXC  = mk(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 2'd3, 1);

    // Reset release, then lw with no wait states.
    add(1, LW, 1, 4'd0, C_RST, 2'd0, 4'd0);
    add(1, LW, 1, 4'd1, C_FR, 2'd0, 4'd0);
    add(1, LW, 1, 4'd2, C_DEC, 2'd0, 4'd0);
    add(1, LW, 1, 4'd3, C_MADR, 2'd0, 4'd0);
    add(1, LW, 1, 4'd4, C_MRD, 2'd0, 4'd0);
    add(1, LW, 1, 4'd5, C_MWB, 2'd0, 4'd0);
    // Three fetch wait cycles, then jal.
    add(1, JAL, 0, 4'd1, C_FW, 2'd0, 4'd1);
    add(1, JAL, 0, 4'd1, C_FW, 2'd0, 4'd1);
    add(1, JAL, 0, 4'd1, C_FW, 2'd0, 4'd1);
    add(1, JAL, 1, 4'd1, C_FR, 2'd0, 4'd1);
    add(1, JAL, 1, 4'd2, C_DEC, 2'd0, 4'd1);
    add(1, JAL, 1, 4'd12, C_JAL, 2'd0, 4'd1);
    // Illegal opcode.
    add(1, BAD, 1, 4'd1, C_FR, 2'd0, 4'd2);
    add(1, BAD, 1, 4'd2, C_DEC, 2'd0, 4'd2);
    add(1, BAD, 1, 4'd13, C_EXC, 2'd1, 4'd2);
    // sw with mem_ready stuck low -> bus timeout after 4 cycles.
    add(1, SW, 1, 4'd1, C_FR, 2'd1, 4'd2);
    add(1, SW, 1, 4'd2, C_DEC, 2'd1, 4'd2);
    add(1, SW, 0, 4'd3, C_MADR, 2'd1, 4'd2);
    add(1, SW, 0, 4'd6, C_MWR, 2'd1, 4'd2);
    add(1, SW, 0, 4'd6, C_MWR, 2'd1, 4'd2);
    add(1, SW, 0, 4'd6, C_MWR, 2'd1, 4'd2);
    add(1, SW, 0, 4'd6, C_MWR, 2'd1, 4'd2);
    add(1, SW, 0, 4'd13, C_EXC, 2'd2, 4'd2);
    // beq, ori, lui.
    add(1, BEQ, 1, 4'd1, C_FR, 2'd2, 4'd2);
    add(1, BEQ, 1, 4'd2, C_DEC, 2'd2, 4'd2);
    add(1, BEQ, 1, 4'd9, C_BR, 2'd2, 4'd2);
    add(1, ORI, 1, 4'd1, C_FR, 2'd2, 4'd3);
    add(1, ORI, 1, 4'd2, C_DEC, 2'd2, 4'd3);
    add(1, ORI, 1, 4'd10, C_ORI, 2'd2, 4'd3);
    add(1, ORI, 1, 4'd11, C_IWB, 2'd2, 4'd3);
    add(1, LUI, 1, 4'd1, C_FR, 2'd2, 4'd4);
    add(1, LUI, 1, 4'd2, C_DEC, 2'd2, 4'd4);
    add(1, LUI, 1, 4'd10, C_LUI, 2'd2, 4'd4);
    add(1, LUI, 1, 4'd11, C_IWB, 2'd2, 4'd4);
    // sw with one wait cycle, then j.
    add(1, SW, 1, 4'd1, C_FR, 2'd2, 4'd5);
    add(1, SW, 1, 4'd2, C_DEC, 2'd2, 4'd5);
    add(1, SW, 0, 4'd3, C_MADR, 2'd2, 4'd5);
    add(1, SW, 0, 4'd6, C_MWR, 2'd2, 4'd5);
    add(1, SW, 1, 4'd6, C_MWR, 2'd2, 4'd5);
    add(1, J, 1, 4'd1, C_FR, 2'd2, 4'd6);
    add(1, J, 1, 4'd2, C_DEC, 2'd2, 4'd6);
    add(1, J, 1, 4'd12, C_J, 2'd2, 4'd6);
    // lw where ready arrives on the 4th cycle: ready wins over timeout.
    add(1, LW, 0, 4'd1, C_FW, 2'd2, 4'd7);
    add(1, LW, 1, 4'd1, C_FR, 2'd2, 4'd7);
    add(1, LW, 1, 4'd2, C_DEC, 2'd2, 4'd7);
    add(1, LW, 0, 4'd3, C_MADR, 2'd2, 4'd7);
    add(1, LW, 0, 4'd4, C_MRD, 2'd2, 4'd7);
    add(1, LW, 0, 4'd4, C_MRD, 2'd2, 4'd7);
    add(1, LW, 0, 4'd4, C_MRD, 2'd2, 4'd7);
    add(1, LW, 1, 4'd4, C_MRD, 2'd2, 4'd7);
    add(1, LW, 1, 4'd5, C_MWB, 2'd2, 4'd7);
    // Reset asserted mid-MEM_READ.
    add(1, LW, 1, 4'd1, C_FR, 2'd2, 4'd8);
    add(1, LW, 1, 4'd2, C_DEC, 2'd2, 4'd8);
    add(1, LW, 0, 4'd3, C_MADR, 2'd2, 4'd8);
    add(0, LW, 0, 4'd4, C_MRD, 2'd2, 4'd8);
    add(1, LW, 0, 4'd0, C_RST, 2'd0, 4'd0);

    reset_n       = 1'b0;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].ctl,
           vecs[i].cause, vecs[i].cnt, $sformatf("vec%0d", i));
    end

    // 17 R-type instructions wrap the 4-bit retire counter to 1.
    for (int k = 0; k < 17; k++) begin
      step(1, RT, 1, 4'd1, C_FR, 2'd0, 4'(k), $sformatf("rtype%0d_fetch", k));
      step(1, RT, 1, 4'd2, C_DEC, 2'd0, 4'(k), $sformatf("rtype%0d_decode", k));
      step(1, RT, 1, 4'd7, C_EXE, 2'd0, 4'(k), $sformatf("rtype%0d_exec", k));
      step(1, RT, 1, 4'd8, C_AWB, 2'd0, 4'(k), $sformatf("rtype%0d_wb", k));
    end
    step(1, RT, 1, 4'd1, C_FR, 2'd0, 4'd1, "rtype_wrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle MIPS control unit. It replaces the opcode truth table with a registered state machine that sequences the shared-memory, shared-ALU datapath over 3–5 cycles per instruction. Memory accesses use a ready handshake with a parametrised timeout. Illegal opcodes and bus timeouts redirect the PC to the exception vector, and a retired-instruction counter runs alongside.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive mem_ready-low cycles tolerated in a memory state before a bus error; 0 disables the timeout.
- CNT_WIDTH, 32: width of retired_count.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the clock edge.
- opcode  in  6  instruction register bits [31:26], valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- mem_read, mem_write  out  1  memory strobes.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write, pc_write, pc_write_cond  out  1  register enables; pc_write_cond is ANDed with ALU zero in the datapath.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  write register: 00 = rt, 01 = rd, 10 = $31.
- mem_to_reg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B: 00 = rt, 01 = 4, 10 = extended immediate, 11 = immediate << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct field, 11 = immediate op.
- immediate_or, immediate_load_upper  out  1  select ori (zero-extend, OR) or lui; valid only in IMM_EXE.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- exception  out  1  one-cycle pulse in EXCEPT.
- cause  out  2  last exception cause: 00 = none, 01 = illegal opcode, 10 = bus timeout.
- retired_count  out  CNT_WIDTH  number of completed instructions.
- state  out  4  current state encoding, for debug.

## Operation
- Outputs are Moore-decoded from the state register, except where noted "on mem_ready".
- Every output not listed for a state is 0.
- RESET (0): all outputs 0. Next state is FETCH.
- FETCH (1): mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. On mem_ready: ir_write=1, pc_write=1, next DECODE.
- DECODE (2): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 → EXECUTE
  - 100011 or 101011 → MEM_ADR
  - 000100 → BRANCH
  - 001101 or 001111 → IMM_EXE
  - 000010 or 000011 → JUMP
  - anything else → EXCEPT with cause 01.
- MEM_ADR (3): alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (4): mem_read, iord=1. On mem_ready → MEM_WB.
- MEM_WB (5): reg_write, reg_dst=00, mem_to_reg=01 → FETCH; retire.
- MEM_WRITE (6): mem_write, iord=1. On mem_ready → FETCH; retire.
- EXECUTE (7): alu_src_a=1, alu_src_b=00, alu_op=10 → ALU_WB.
- ALU_WB (8): reg_write, reg_dst=01, mem_to_reg=00 → FETCH; retire.
- BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01 → FETCH; retire.
- IMM_EXE (10): alu_src_a=1, alu_src_b=10, alu_op=11, immediate_or = (opcode==001101), immediate_load_upper = (opcode==001111) → IMM_WB.
- IMM_WB (11): reg_write, reg_dst=00, mem_to_reg=00 → FETCH; retire.
- JUMP (12): pc_write, pc_source=10. For jal also reg_write, reg_dst=10, mem_to_reg=10 (the PC is already PC+4) → FETCH; retire.
- EXCEPT (13): pc_write, pc_source=11, exception=1 → FETCH. No retire.
- Unused encodings (14, 15) → RESET.
- Retire: retired_count increments by 1 on the transition out of a retiring state; wraps modulo 2^CNT_WIDTH.
- cause is loaded on entry to EXCEPT and holds until the next exception or reset.

## Timing
- Reset: while reset_n is 0 at a clock edge, the next state is RESET, retired_count=0, cause=00, and the timeout counter is 0.
  - Reset overrides any in-progress access; no strobe survives past the reset edge.
- Cycle counts with mem_ready high on the first cycle:
  - lw: 5
  - sw, R-type, ori, lui: 4
  - beq, j, jal: 3
  - Each low mem_ready cycle adds 1.
- Timeout counter:
  - Clears on entry to FETCH, MEM_READ and MEM_WRITE.
  - Counts cycles with mem_ready low.
  - If MEM_TIMEOUT>0 and the MEM_TIMEOUT-th consecutive low cycle is reached, the next state is EXCEPT with cause 10. ir_write and pc_write are not asserted.
  - mem_ready high on that same cycle wins: normal advance.
- An access ends in exactly one cycle with mem_ready=1. mem_ready outside a memory state is ignored.

## Test plan
- Hold reset_n low for 2 cycles, then release → state=0 for one cycle, then 1; all outputs 0 in RESET; retired_count=0.
- lw (opcode 100011), mem_ready always 1 → state sequence 1,2,3,4,5,1; reg_write only in 5 with mem_to_reg=01; retired_count=1.
- FETCH with mem_ready low for 3 cycles, then a jal → ir_write exactly once, on cycle 4; JUMP asserts pc_write, reg_dst=10, mem_to_reg=10.
- Opcode 111111 → DECODE goes to EXCEPT; exception=1 and pc_source=11 for 1 cycle; cause=01; retired_count unchanged.
- MEM_TIMEOUT=4, sw with mem_ready stuck low → MEM_WRITE lasts 4 cycles, then EXCEPT with cause=10, then FETCH.
- CNT_WIDTH=4: retire 17 R-type instructions → retired_count=1 (wrapped). Assert reset_n mid-MEM_READ → mem_read=0 from the next cycle.
